// File: rtl/rab_l2_req_pkg.sv
// -----------------------------------------------------------------------------
// rab_l2_req_pkg
// Shared types for the L2 TLB requester: the control FSM state encoding and
// the error codes reported on the error channel.
// -----------------------------------------------------------------------------
package rab_l2_req_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FWD   = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Encoding is visible on err_code_o, so the values are fixed.
    typedef enum logic [1:0] {
        ERR_MISS    = 2'd0,
        ERR_PROT    = 2'd1,
        ERR_MULTI   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage : rab_l2_req_pkg

// File: rtl/rab_l2_req_if.sv
// -----------------------------------------------------------------------------
// rab_l2_req_if
// Valid/ready request channel carrying one L1-miss transaction
// (address, read/write flag, transaction ID).
//   master : drives valid + payload, samples ready
//   slave  : samples valid + payload, drives ready
// -----------------------------------------------------------------------------
interface rab_l2_req_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();

    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw;
    logic [ID_WIDTH-1:0]   id;

    modport master (output valid, addr, rw, id, input  ready);
    modport slave  (input  valid, addr, rw, id, output ready);

endinterface : rab_l2_req_if

// File: rtl/rab_l2_req_fifo.sv
// -----------------------------------------------------------------------------
// rab_l2_req_fifo
// Synchronous FIFO for pending L1-miss transactions.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   push_if (slave)   : push handshake; ready = !full, so no push while full
//                       even when a pop happens in the same cycle
//   pop_i             : drop the head entry (ignored when empty)
//   full_o, empty_o   : occupancy flags
//   head_*_o          : payload of the oldest entry
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter.
// -----------------------------------------------------------------------------
module rab_l2_req_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rab_l2_req_if.slave           push_if,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH-1:0] head_addr_o,
    output logic                  head_rw_o,
    output logic [ID_WIDTH-1:0]   head_id_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int DATA_W = ADDR_WIDTH + ID_WIDTH + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push;
    logic              pop;

    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign push_if.ready = !full_o;
    assign push          = push_if.valid && !full_o;
    assign pop           = pop_i && !empty_o;

    assign {head_rw_o, head_id_o, head_addr_o} = mem_q[rd_ptr_q[IDX_W-1:0]];

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers define which
    // entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= {push_if.rw, push_if.id, push_if.addr};
    end

endmodule : rab_l2_req_fifo

// File: rtl/rab_l2_req.sv
// -----------------------------------------------------------------------------
// rab_l2_req
// L1-miss requester for the L2 TLB. Buffers missed transactions, issues one
// lookup at a time, and routes the result:
//   hit                       -> forward channel with translated address,
//                                l2_trans_sent_o pulsed on accept
//   miss / prot / multi-hit   -> error channel (codes 0 / 1 / 2)
//   no result in time         -> error channel (code 3), l2_trans_sent_o
//                                pulsed on accept to pull the TLB out of DONE
// Ports:
//   clk_i, rst_i                       : clock, async active-high reset
//   req_*                              : L1-miss push handshake + payload
//   l1_miss_o, in_addr_o, rw_type_o    : lookup start pulse + payload
//   l2_busy_i                          : TLB busy, blocks a new lookup
//   hit/miss/prot/multiple_hit_l2_i,
//   out_addr_i                         : TLB result pulses + translation
//   l2_trans_sent_o                    : release pulse to the TLB
//   fwd_*                              : translated-transaction handshake
//   err_*                              : error handshake + addr/id/code
// -----------------------------------------------------------------------------
module rab_l2_req
    import rab_l2_req_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_rw_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,

    output logic                  l1_miss_o,
    output logic [ADDR_WIDTH-1:0] in_addr_o,
    output logic                  rw_type_o,
    input  logic                  l2_busy_i,
    input  logic                  hit_l2_i,
    input  logic                  miss_l2_i,
    input  logic                  prot_l2_i,
    input  logic                  multiple_hit_l2_i,
    input  logic [ADDR_WIDTH-1:0] out_addr_i,
    output logic                  l2_trans_sent_o,

    output logic                  fwd_valid_o,
    input  logic                  fwd_ready_i,
    output logic [ADDR_WIDTH-1:0] fwd_addr_o,
    output logic                  fwd_rw_o,
    output logic [ID_WIDTH-1:0]   fwd_id_o,

    output logic                  err_valid_o,
    input  logic                  err_ready_i,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [ID_WIDTH-1:0]   err_id_o,
    output logic [1:0]            err_code_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    err_code_t             err_code_q, err_code_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  head_rw;
    logic [ID_WIDTH-1:0]   head_id;

    // ------------------------------------------------------------------
    // Request buffer
    // ------------------------------------------------------------------
    rab_l2_req_if #(.ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) req_if ();

    assign req_if.valid = req_valid_i;
    assign req_if.addr  = req_addr_i;
    assign req_if.rw    = req_rw_i;
    assign req_if.id    = req_id_i;
    // Held low while reset is asserted so every output reads 0 in reset.
    assign req_ready_o  = req_if.ready && !rst_i;

    rab_l2_req_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_if     (req_if.slave),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_addr_o (head_addr),
        .head_rw_o   (head_rw),
        .head_id_o   (head_id)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fwd_addr_q <= '0;
            err_code_q <= ERR_MISS;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fwd_addr_q <= fwd_addr_d;
            err_code_q <= err_code_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fwd_addr_d = fwd_addr_q;
        err_code_d = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !l2_busy_i) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Multi-hit outranks prot, prot outranks miss, any fault
                // outranks a hit.
                if (multiple_hit_l2_i) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_MULTI;
                end else if (prot_l2_i) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_PROT;
                end else if (miss_l2_i) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_MISS;
                end else if (hit_l2_i) begin
                    state_d    = ST_FWD;
                    fwd_addr_d = out_addr_i;
                end else begin
                    // Saturating count; the ERR transition fires on the
                    // TIMEOUT_CYCLES-th silent WAIT cycle.
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q >= CNT_LAST) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
            end
            ST_FWD: begin
                if (fwd_ready_i) state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (err_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        l1_miss_o       = 1'b0;
        in_addr_o       = '0;
        rw_type_o       = 1'b0;
        l2_trans_sent_o = 1'b0;
        fwd_valid_o     = 1'b0;
        fwd_addr_o      = '0;
        fwd_rw_o        = 1'b0;
        fwd_id_o        = '0;
        err_valid_o     = 1'b0;
        err_addr_o      = '0;
        err_id_o        = '0;
        err_code_o      = 2'd0;
        pop             = 1'b0;

        // The head stays in place until the pop, so the lookup payload is
        // stable from ISSUE through the final handshake.
        if (state_q != ST_IDLE) begin
            in_addr_o = head_addr;
            rw_type_o = head_rw;
        end

        unique case (state_q)
            ST_ISSUE: l1_miss_o = 1'b1;
            ST_FWD: begin
                fwd_valid_o = 1'b1;
                fwd_addr_o  = fwd_addr_q;
                fwd_rw_o    = head_rw;
                fwd_id_o    = head_id;
                if (fwd_ready_i) begin
                    l2_trans_sent_o = 1'b1;
                    pop             = 1'b1;
                end
            end
            ST_ERR: begin
                err_valid_o = 1'b1;
                err_addr_o  = head_addr;
                err_id_o    = head_id;
                err_code_o  = err_code_q;
                if (err_ready_i) begin
                    // A timed-out TLB is still holding its lookup and must
                    // be released; a reported fault has already finished.
                    l2_trans_sent_o = (err_code_q == ERR_TIMEOUT);
                    pop             = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule : rab_l2_req

// File: tb/tb_rab_l2_req.sv
// -----------------------------------------------------------------------------
// tb_rab_l2_req
// Directed bench for rab_l2_req with TIMEOUT_CYCLES = 8 and FIFO_DEPTH = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_rab_l2_req;

    localparam int AW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          l1_miss, rw_type, l2_busy;
    logic [AW-1:0] in_addr, out_addr;
    logic          hit, miss, prot, multi, trans_sent;
    logic          fwd_valid, fwd_ready, fwd_rw;
    logic [AW-1:0] fwd_addr;
    logic [IW-1:0] fwd_id;
    logic          err_valid, err_ready;
    logic [AW-1:0] err_addr;
    logic [IW-1:0] err_id;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    rab_l2_req_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) req_if ();

    always #5 clk = ~clk;

    rab_l2_req #(
        .ADDR_WIDTH     (AW),
        .ID_WIDTH       (IW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_if.valid),
        .req_ready_o       (req_if.ready),
        .req_addr_i        (req_if.addr),
        .req_rw_i          (req_if.rw),
        .req_id_i          (req_if.id),
        .l1_miss_o         (l1_miss),
        .in_addr_o         (in_addr),
        .rw_type_o         (rw_type),
        .l2_busy_i         (l2_busy),
        .hit_l2_i          (hit),
        .miss_l2_i         (miss),
        .prot_l2_i         (prot),
        .multiple_hit_l2_i (multi),
        .out_addr_i        (out_addr),
        .l2_trans_sent_o   (trans_sent),
        .fwd_valid_o       (fwd_valid),
        .fwd_ready_i       (fwd_ready),
        .fwd_addr_o        (fwd_addr),
        .fwd_rw_o          (fwd_rw),
        .fwd_id_o          (fwd_id),
        .err_valid_o       (err_valid),
        .err_ready_i       (err_ready),
        .err_addr_o        (err_addr),
        .err_id_o          (err_id),
        .err_code_o        (err_code)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes one request; bounded so a stuck ready cannot hang the run.
    task automatic push_req(input logic [AW-1:0] a, input logic rw, input logic [IW-1:0] id);
        int n = 0;
        req_if.valid = 1'b1;
        req_if.addr  = a;
        req_if.rw    = rw;
        req_if.id    = id;
        while (!req_if.ready && n < 50) begin
            step();
            n++;
        end
        step();
        req_if.valid = 1'b0;
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL push_accept: id %0d not accepted within 50 cycles", id);
        end
    endtask

    // Returns the number of cycles until l1_miss is seen, or -1 on timeout.
    task automatic wait_issue(output int n);
        n = 0;
        while (!l1_miss && n < 20) begin
            step();
            n++;
        end
        if (!l1_miss) n = -1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({req_if.ready, l1_miss, fwd_valid, err_valid, trans_sent, err_code} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {req_if.ready, l1_miss, fwd_valid, err_valid, trans_sent, err_code});
        end
        checks++;
        if ({in_addr, fwd_addr, err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: in %h fwd %h err %h required 0", in_addr, fwd_addr, err_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (req_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_if.ready);
        end
        step();
    endtask

    task automatic test_single_hit();
        int pulses = 0;
        req_if.valid = 1'b1;
        req_if.addr  = 32'h1000_0ABC;
        req_if.rw    = 1'b0;
        req_if.id    = 4'd3;
        step();
        req_if.valid = 1'b0;
        checks++;
        if (l1_miss !== 1'b0) begin
            errors++;
            $display("FAIL hit_latency_early: l1_miss %b required 0", l1_miss);
        end
        step();
        checks++;
        if ({l1_miss, in_addr, rw_type} !== {1'b1, 32'h1000_0ABC, 1'b0}) begin
            errors++;
            $display("FAIL hit_issue: l1_miss %b in_addr %h rw %b required 1 10000abc 0",
                     l1_miss, in_addr, rw_type);
        end
        step();
        checks++;
        if (l1_miss !== 1'b0) begin
            errors++;
            $display("FAIL hit_issue_pulse: l1_miss %b required 0", l1_miss);
        end
        repeat (3) step();
        hit      = 1'b1;
        out_addr = 32'h8000_0ABC;
        step();
        hit      = 1'b0;
        out_addr = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({fwd_valid, fwd_addr, fwd_id, fwd_rw, trans_sent, err_valid} !==
            {1'b1, 32'h8000_0ABC, 4'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hit_fwd: valid %b addr %h id %0d rw %b sent %b errv %b required 1 80000abc 3 0 0 0",
                     fwd_valid, fwd_addr, fwd_id, fwd_rw, trans_sent, err_valid);
        end
        fwd_ready = 1'b1;
        #1;
        checks++;
        if (trans_sent !== 1'b1) begin
            errors++;
            $display("FAIL hit_trans_sent: got %b required 1", trans_sent);
        end
        step();
        fwd_ready = 1'b0;
        #1;
        checks++;
        if ({fwd_valid, trans_sent} !== 2'b00) begin
            errors++;
            $display("FAIL hit_after_accept: valid %b sent %b required 0 0", fwd_valid, trans_sent);
        end
        repeat (5) begin
            step();
            if (l1_miss) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL hit_fifo_empty: %0d extra lookups required 0", pulses);
        end
    endtask

    task automatic test_priority();
        logic [3:0] vec  [3] = '{4'b1100, 4'b0110, 4'b0011}; // {multi,prot,miss,hit}
        logic [1:0] code [3] = '{2'd2, 2'd1, 2'd0};
        int n;
        for (int i = 0; i < 3; i++) begin
            push_req(32'h2000_0123 + 32'(i), 1'b1, IW'(5 + i));
            wait_issue(n);
            checks++;
            if (n < 0) begin
                errors++;
                $display("FAIL prio_issue[%0d]: no lookup issued", i);
            end
            step();
            {multi, prot, miss, hit} = vec[i];
            step();
            {multi, prot, miss, hit} = 4'b0000;
            #1;
            checks++;
            if ({err_valid, fwd_valid, err_code, err_addr, err_id} !==
                {1'b1, 1'b0, code[i], 32'h2000_0123 + 32'(i), IW'(5 + i)}) begin
                errors++;
                $display("FAIL prio_err[%0d]: errv %b fwdv %b code %0d addr %h id %0d required 1 0 %0d %h %0d",
                         i, err_valid, fwd_valid, err_code, err_addr, err_id,
                         code[i], 32'h2000_0123 + 32'(i), 5 + i);
            end
            err_ready = 1'b1;
            #1;
            checks++;
            if (trans_sent !== 1'b0) begin
                errors++;
                $display("FAIL prio_no_release[%0d]: sent %b required 0", i, trans_sent);
            end
            step();
            err_ready = 1'b0;
            #1;
            checks++;
            if (err_valid !== 1'b0) begin
                errors++;
                $display("FAIL prio_accept[%0d]: errv %b required 0", i, err_valid);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int early = 0;
        push_req(32'h3000_0044, 1'b0, 4'd7);
        wait_issue(n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL to_issue: no lookup issued");
        end
        step();
        for (int i = 1; i <= 8; i++) begin
            if (err_valid) early++;
            step();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early: err_valid seen in %0d of 8 WAIT cycles required 0", early);
        end
        checks++;
        if ({err_valid, err_code, err_addr, err_id} !== {1'b1, 2'd3, 32'h3000_0044, 4'd7}) begin
            errors++;
            $display("FAIL to_err: errv %b code %0d addr %h id %0d required 1 3 30000044 7",
                     err_valid, err_code, err_addr, err_id);
        end
        miss = 1'b1;
        step();
        miss = 1'b0;
        #1;
        checks++;
        if ({err_valid, err_code} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL to_ignore_pulse: errv %b code %0d required 1 3", err_valid, err_code);
        end
        err_ready = 1'b1;
        #1;
        checks++;
        if (trans_sent !== 1'b1) begin
            errors++;
            $display("FAIL to_release: sent %b required 1", trans_sent);
        end
        step();
        err_ready = 1'b0;
        #1;
        checks++;
        if ({err_valid, trans_sent} !== 2'b00) begin
            errors++;
            $display("FAIL to_accept: errv %b sent %b required 0 0", err_valid, trans_sent);
        end
    endtask

    task automatic test_full_order();
        int  n;
        int  seen = 0;
        bit  stable;
        l2_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_req(32'h4000_0000 + 32'(i * 16), i[0], IW'(i));
        req_if.valid = 1'b1;
        req_if.addr  = 32'h4000_0040;
        req_if.rw    = 1'b0;
        req_if.id    = 4'd4;
        #1;
        checks++;
        if (req_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b required 0", req_if.ready);
        end
        repeat (3) begin
            step();
            if (req_if.ready || l1_miss) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL full_stall: ready/l1_miss high in %0d cycles required 0", seen);
        end
        l2_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_issue(n);
            checks++;
            if (n < 0 || in_addr !== 32'h4000_0000 + 32'(i * 16)) begin
                errors++;
                $display("FAIL order_issue[%0d]: wait %0d in_addr %h required %h",
                         i, n, in_addr, 32'h4000_0000 + 32'(i * 16));
            end
            step();
            hit      = 1'b1;
            out_addr = 32'h9000_0000 + 32'(i);
            step();
            hit = 1'b0;
            #1;
            checks++;
            if ({fwd_valid, fwd_addr, fwd_id, fwd_rw} !==
                {1'b1, 32'h9000_0000 + 32'(i), IW'(i), (i == 4) ? 1'b0 : i[0]}) begin
                errors++;
                $display("FAIL order_fwd[%0d]: valid %b addr %h id %0d rw %b required 1 %h %0d",
                         i, fwd_valid, fwd_addr, fwd_id, fwd_rw, 32'h9000_0000 + 32'(i), i);
            end
            if (i == 0) begin
                stable = 1'b1;
                repeat (10) begin
                    step();
                    if (!fwd_valid || fwd_addr !== 32'h9000_0000 || fwd_id !== 4'd0 || err_valid)
                        stable = 1'b0;
                end
                checks++;
                if (!stable) begin
                    errors++;
                    $display("FAIL order_hold: payload changed while fwd_ready low, now valid %b addr %h id %0d",
                             fwd_valid, fwd_addr, fwd_id);
                end
            end
            fwd_ready = 1'b1;
            #1;
            checks++;
            if (trans_sent !== 1'b1) begin
                errors++;
                $display("FAIL order_release[%0d]: sent %b required 1", i, trans_sent);
            end
            step();
            fwd_ready = 1'b0;
            #1;
            checks++;
            if (l1_miss !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: l1_miss %b in first IDLE cycle required 0", i, l1_miss);
            end
            if (i == 0) begin
                // The pop edge must not also have taken the stalled request.
                checks++;
                if (req_if.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_pop_push: ready %b after pop required 1", req_if.ready);
                end
                step();
                req_if.valid = 1'b0;
                checks++;
                if (req_if.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_refill: ready %b required 0", req_if.ready);
                end
            end
        end
    endtask

    task automatic test_busy();
        int pulses = 0;
        l2_busy = 1'b1;
        push_req(32'h5000_0000, 1'b1, 4'd9);
        repeat (6) begin
            step();
            if (l1_miss) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL busy_block: %0d lookups while busy required 0", pulses);
        end
        l2_busy = 1'b0;
        pulses  = 0;
        repeat (6) begin
            step();
            if (l1_miss) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL busy_release: %0d lookups required 1", pulses);
        end
        hit      = 1'b1;
        out_addr = 32'hA000_0000;
        step();
        hit = 1'b0;
        #1;
        checks++;
        if ({fwd_valid, fwd_id, fwd_rw} !== {1'b1, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL busy_fwd: valid %b id %0d rw %b required 1 9 1", fwd_valid, fwd_id, fwd_rw);
        end
        fwd_ready = 1'b1;
        step();
        fwd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int pulses = 0;
        push_req(32'h6000_0000, 1'b0, 4'd2);
        wait_issue(n);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({n < 0, l1_miss, fwd_valid, err_valid, trans_sent, req_if.ready, in_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: wait %0d l1 %b fwdv %b errv %b sent %b ready %b in_addr %h required all 0",
                     n, l1_miss, fwd_valid, err_valid, trans_sent, req_if.ready, in_addr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        hit      = 1'b1;
        out_addr = 32'h7000_0000;
        step();
        hit = 1'b0;
        #1;
        checks++;
        if ({fwd_valid, err_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_hit_ignored: fwdv %b errv %b required 0 0", fwd_valid, err_valid);
        end
        repeat (5) begin
            step();
            if (l1_miss) pulses++;
        end
        checks++;
        if (pulses != 0 || req_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_fifo_empty: lookups %0d ready %b required 0 1", pulses, req_if.ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        req_if.valid = 1'b0;
        req_if.addr  = '0;
        req_if.rw    = 1'b0;
        req_if.id    = '0;
        l2_busy      = 1'b0;
        hit          = 1'b0;
        miss         = 1'b0;
        prot         = 1'b0;
        multi        = 1'b0;
        out_addr     = '0;
        fwd_ready    = 1'b0;
        err_ready    = 1'b0;

        test_reset();
        test_single_hit();
        test_priority();
        test_timeout();
        test_full_order();
        test_busy();
        test_reset_mid_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rab_l2_req
